// File: rtl/matrix_input_parser_if.sv
// Byte-stream and storage-write bundle between UART RX, the matrix input parser and storage.
interface matrix_input_parser_if #(
  parameter int DATA_WIDTH = 9
);
  logic                     i_enable;
  logic [7:0]               i_rx_data;
  logic                     i_rx_valid;
  logic                     o_busy;
  logic                     o_wr_en;
  logic [2:0]               o_wr_row;
  logic [2:0]               o_wr_col;
  logic [25*DATA_WIDTH-1:0] o_wr_data;
  logic                     o_done;
  logic                     o_err;
  logic [1:0]               o_err_code;

  modport master (
    output i_enable, i_rx_data, i_rx_valid,
    input  o_busy, o_wr_en, o_wr_row, o_wr_col, o_wr_data, o_done, o_err, o_err_code
  );

  modport slave (
    input  i_enable, i_rx_data, i_rx_valid,
    output o_busy, o_wr_en, o_wr_row, o_wr_col, o_wr_data, o_done, o_err, o_err_code
  );
endinterface

// File: rtl/matrix_input_parser.sv
// ASCII "R C e0 .. e(R*C-1)" parser feeding one flattened write into matrix storage.
// Optional MATRIX_PARSER_CLAMP_EN: oversized elements clamp to ELEM_MAX instead of erroring.
module matrix_input_parser #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_DIM    = 5,
  parameter int ELEM_MAX   = 511
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_input_parser_if.slave bus
);
  localparam int                    SLOTS     = 25;
  localparam logic [15:0]           LP_EMAX   = 16'(ELEM_MAX);
  localparam logic [11:0]           LP_SAT    = 12'(ELEM_MAX + 1);
  localparam logic [11:0]           LP_DIMMAX = 12'(MAX_DIM);
  localparam logic [DATA_WIDTH-1:0] LP_CLAMP  = DATA_WIDTH'(ELEM_MAX);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ELEM, S_WRITE, S_FLUSH} state_t;

  state_t                        r_state;
  logic [11:0]                   r_acc;
  logic                          r_ovf;
  logic                          r_tok;
  logic [2:0]                    r_rows;
  logic [2:0]                    r_cols;
  logic [4:0]                    r_idx;
  logic                          r_busy;
  logic                          r_wr_en;
  logic                          r_done;
  logic                          r_err;
  logic [1:0]                    r_err_code;
  logic [2:0]                    r_wr_row;
  logic [2:0]                    r_wr_col;
  logic [SLOTS*DATA_WIDTH-1:0]   r_wr_data;

  logic                  w_is_digit;
  logic                  w_is_sep;
  logic                  w_is_lf;
  logic [15:0]           w_acc_mul;
  logic [11:0]           w_acc_step;
  logic                  w_ovf_step;
  logic                  w_dim_ok;
  logic                  w_elem_ok;
  logic [DATA_WIDTH-1:0] w_elem_val;
  logic [5:0]            w_total;
  logic [4:0]            w_idx_next;
  logic                  w_last;
  state_t                w_fail_state;
  logic                  w_fail_busy;

  // Byte classification, saturating token arithmetic and commit qualifiers
  always_comb begin
    w_is_digit = (bus.i_rx_data >= 8'h30) && (bus.i_rx_data <= 8'h39);
    w_is_lf    = (bus.i_rx_data == 8'h0A);
    w_is_sep   = w_is_lf || (bus.i_rx_data == 8'h20) || (bus.i_rx_data == 8'h0D);
    w_acc_mul  = ({4'd0, r_acc} * 16'd10) + {12'd0, bus.i_rx_data[3:0]};
    if (w_acc_mul > LP_EMAX) begin
      w_acc_step = LP_SAT;
      w_ovf_step = 1'b1;
    end else begin
      w_acc_step = w_acc_mul[11:0];
      w_ovf_step = r_ovf;
    end
    w_dim_ok = !r_ovf && (r_acc != 12'd0) && (r_acc <= LP_DIMMAX);
`ifdef MATRIX_PARSER_CLAMP_EN
    w_elem_ok  = 1'b1;
    w_elem_val = r_ovf ? LP_CLAMP : r_acc[DATA_WIDTH-1:0];
`else
    w_elem_ok  = !r_ovf;
    w_elem_val = r_acc[DATA_WIDTH-1:0];
`endif
    w_total    = {3'd0, r_rows} * {3'd0, r_cols};
    w_idx_next = r_idx + 5'd1;
    w_last     = ({1'b0, w_idx_next} == w_total);
    // An error raised by the LF itself already ends the line, so there is nothing to flush.
    if (w_is_lf) begin
      w_fail_state = S_IDLE;
      w_fail_busy  = 1'b0;
    end else begin
      w_fail_state = S_FLUSH;
      w_fail_busy  = r_busy;
    end
  end

  // Parser FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_acc      <= 12'd0;
      r_ovf      <= 1'b0;
      r_tok      <= 1'b0;
      r_rows     <= 3'd0;
      r_cols     <= 3'd0;
      r_idx      <= 5'd0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_wr_row   <= 3'd0;
      r_wr_col   <= 3'd0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (!bus.i_enable) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
        r_acc   <= 12'd0;
        r_ovf   <= 1'b0;
        r_tok   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.i_rx_valid) begin
              if (w_is_digit) begin
                r_acc   <= {8'd0, bus.i_rx_data[3:0]};
                r_ovf   <= 1'b0;
                r_tok   <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= S_ROW;
              end else if (!w_is_sep) begin
                r_err      <= 1'b1;
                r_err_code <= 2'd3;
                r_state    <= S_FLUSH;
              end
            end
          end
          S_ROW, S_COL, S_ELEM: begin
            if (bus.i_rx_valid) begin
              if (w_is_digit) begin
                r_acc <= w_acc_step;
                r_ovf <= w_ovf_step;
                r_tok <= 1'b1;
              end else if (w_is_sep) begin
                if (r_tok) begin
                  r_acc <= 12'd0;
                  r_ovf <= 1'b0;
                  r_tok <= 1'b0;
                  case (r_state)
                    S_ROW: begin
                      if (w_dim_ok) begin
                        r_rows  <= r_acc[2:0];
                        r_state <= S_COL;
                      end else begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= w_fail_state;
                        r_busy     <= w_fail_busy;
                      end
                    end
                    S_COL: begin
                      if (w_dim_ok) begin
                        r_cols    <= r_acc[2:0];
                        r_idx     <= 5'd0;
                        r_wr_data <= '0;
                        r_state   <= S_ELEM;
                      end else begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd1;
                        r_state    <= w_fail_state;
                        r_busy     <= w_fail_busy;
                      end
                    end
                    default: begin
                      if (!w_elem_ok) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'd2;
                        r_state    <= w_fail_state;
                        r_busy     <= w_fail_busy;
                      end else begin
                        r_wr_data[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH] <= w_elem_val;
                        r_idx <= w_idx_next;
                        if (w_last) begin
                          r_state  <= S_WRITE;
                          r_wr_en  <= 1'b1;
                          r_done   <= 1'b1;
                          r_wr_row <= r_rows;
                          r_wr_col <= r_cols;
                        end
                      end
                    end
                  endcase
                end
              end else begin
                r_err      <= 1'b1;
                r_err_code <= 2'd3;
                r_state    <= S_FLUSH;
              end
            end
          end
          S_WRITE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          S_FLUSH: begin
            if (bus.i_rx_valid && w_is_lf) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.o_busy     = r_busy;
  assign bus.o_wr_en    = r_wr_en;
  assign bus.o_wr_row   = r_wr_row;
  assign bus.o_wr_col   = r_wr_col;
  assign bus.o_wr_data  = r_wr_data;
  assign bus.o_done     = r_done;
  assign bus.o_err      = r_err;
  assign bus.o_err_code = r_err_code;
endmodule

// File: tb/tb_matrix_input_parser.sv
// Directed bench for matrix_input_parser: ASCII entry strings with hand-computed results.
module tb_matrix_input_parser;
  localparam int DW  = 9;
  localparam int WDW = 25*DW;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_wr = 0;
  int   n_done = 0;
  int   n_err = 0;
  logic [WDW-1:0] cap_data = '0;
  logic [2:0]     cap_row = 3'd0;
  logic [2:0]     cap_col = 3'd0;
  logic           cap_done = 1'b0;

  matrix_input_parser_if #(.DATA_WIDTH(DW)) bus ();

  matrix_input_parser #(.DATA_WIDTH(DW), .MAX_DIM(5), .ELEM_MAX(511)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts write/done/err pulses and captures each write
  always @(negedge clk) begin
    if (bus.o_wr_en === 1'b1) begin
      n_wr     <= n_wr + 1;
      cap_data <= bus.o_wr_data;
      cap_row  <= bus.o_wr_row;
      cap_col  <= bus.o_wr_col;
      cap_done <= bus.o_done;
    end
    if (bus.o_done === 1'b1) n_done <= n_done + 1;
    if (bus.o_err === 1'b1) n_err <= n_err + 1;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    idle(2);
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.o_wr_en); end
    n_cmp++; if (bus.o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.o_done); end
    n_cmp++; if (bus.o_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.o_err); end
    n_cmp++; if (bus.o_err_code !== 2'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", bus.o_err_code); end
    n_cmp++; if (bus.o_wr_row !== 3'd0 || bus.o_wr_col !== 3'd0) begin n_bad++; $display("FAIL reset_dims: got %0d/%0d want 0/0", bus.o_wr_row, bus.o_wr_col); end
    n_cmp++; if (bus.o_wr_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.o_wr_data); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.i_enable = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    int w0 = n_wr;
    int d0 = n_done;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    for (int i = 0; i < 6; i++) exp[i*DW +: DW] = 9'(i + 1);
    send_str("2");
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_hi: got %b want 1", bus.o_busy); end
    send_str(" 3 1 2 3 4 5 6\n");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 1) begin n_bad++; $display("FAIL basic_wr_cnt: got %0d want 1", n_wr - w0); end
    n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", n_done - d0); end
    n_cmp++; if (cap_done !== 1'b1) begin n_bad++; $display("FAIL basic_done_with_wr: got %b want 1", cap_done); end
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL basic_err_cnt: got %0d want 0", n_err - e0); end
    n_cmp++; if (cap_row !== 3'd2 || cap_col !== 3'd3) begin n_bad++; $display("FAIL basic_dims: got %0d/%0d want 2/3", cap_row, cap_col); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL basic_data: got %h want %h", cap_data, exp); end
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_lo: got %b want 0", bus.o_busy); end
  endtask

  task automatic test_separators;
    int w0 = n_wr;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW] = 9'd511;
    send_str("  1\r\n1\n\n511 ");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 1) begin n_bad++; $display("FAIL sep_wr_cnt: got %0d want 1", n_wr - w0); end
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL sep_err_cnt: got %0d want 0", n_err - e0); end
    n_cmp++; if (cap_row !== 3'd1 || cap_col !== 3'd1) begin n_bad++; $display("FAIL sep_dims: got %0d/%0d want 1/1", cap_row, cap_col); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL sep_data: got %h want %h", cap_data, exp); end
  endtask

  task automatic test_bad_dim;
    int w0 = n_wr;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW] = 9'd7;
    send_str("6 ");
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd1) begin n_bad++; $display("FAIL dim_err: got err=%b code=%0d want 1/1", bus.o_err, bus.o_err_code); end
    send_str("2 3");
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL dim_flush_busy: got %b want 1", bus.o_busy); end
    send_str("\n");
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL dim_idle_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (n_wr - w0 !== 0) begin n_bad++; $display("FAIL dim_no_wr: got %0d want 0", n_wr - w0); end
    send_str("1 1 7 ");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 1) begin n_bad++; $display("FAIL dim_recover_wr: got %0d want 1", n_wr - w0); end
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL dim_err_cnt: got %0d want 1", n_err - e0); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL dim_recover_data: got %h want %h", cap_data, exp); end
  endtask

  task automatic test_elem_ovf;
    int w0 = n_wr;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW]  = 9'd5;
    exp[DW +: DW] = 9'd511;
    send_str("1 2 5 600 ");
    idle(3);
`ifdef MATRIX_PARSER_CLAMP_EN
    n_cmp++; if (n_wr - w0 !== 1) begin n_bad++; $display("FAIL ovf_clamp_wr: got %0d want 1", n_wr - w0); end
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL ovf_clamp_err: got %0d want 0", n_err - e0); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL ovf_clamp_data: got %h want %h", cap_data, exp); end
`else
    n_cmp++; if (n_wr - w0 !== 0) begin n_bad++; $display("FAIL ovf_no_wr: got %0d want 0", n_wr - w0); end
    n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL ovf_err_cnt: got %0d want 1", n_err - e0); end
    n_cmp++; if (bus.o_err_code !== 2'd2) begin n_bad++; $display("FAIL ovf_code: got %0d want 2", bus.o_err_code); end
    n_cmp++; if (cap_data === exp) begin n_bad++; $display("FAIL ovf_discard: got %h want no such write", cap_data); end
`endif
    send_str("\n");
  endtask

  task automatic test_illegal;
    int w0 = n_wr;
    int e0 = n_err;
    send_str("2 2 1 a");
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd3) begin n_bad++; $display("FAIL ill_err: got err=%b code=%0d want 1/3", bus.o_err, bus.o_err_code); end
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL ill_busy_hi: got %b want 1", bus.o_busy); end
    send_str("\n");
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL ill_busy_lo: got %b want 0", bus.o_busy); end
    send_str("x");
    n_cmp++; if (bus.o_err !== 1'b1 || bus.o_err_code !== 2'd3) begin n_bad++; $display("FAIL ill_idle_err: got err=%b code=%0d want 1/3", bus.o_err, bus.o_err_code); end
    send_str("\n");
    idle(3);
    n_cmp++; if (n_err - e0 !== 2 || n_wr - w0 !== 0) begin n_bad++; $display("FAIL ill_counts: got err=%0d wr=%0d want 2/0", n_err - e0, n_wr - w0); end
    n_cmp++; if (bus.o_err_code !== 2'd3) begin n_bad++; $display("FAIL ill_code_hold: got %0d want 3", bus.o_err_code); end
  endtask

  task automatic test_abort;
    int w0 = n_wr;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW] = 9'd8;
    send_str("3 3 1 2");
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_hi: got %b want 1", bus.o_busy); end
    @(negedge clk);
    bus.i_enable = 1'b0;
    @(negedge clk);
    bus.i_enable = 1'b1;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_lo: got %b want 0", bus.o_busy); end
    idle(2);
    n_cmp++; if (n_wr - w0 !== 0 || n_err - e0 !== 0) begin n_bad++; $display("FAIL abort_quiet: got wr=%0d err=%0d want 0/0", n_wr - w0, n_err - e0); end
    send_str("1 1 8 ");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 1) begin n_bad++; $display("FAIL abort_recover_wr: got %0d want 1", n_wr - w0); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL abort_recover_data: got %h want %h", cap_data, exp); end
  endtask

  task automatic test_back_to_back;
    int w0 = n_wr;
    int e0 = n_err;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW] = 9'd4;
    // The '9' lands in the write cycle and must be dropped, else "91" would be a bad row count.
    send_str("1 1 7 91 1 4 ");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 2) begin n_bad++; $display("FAIL b2b_wr_cnt: got %0d want 2", n_wr - w0); end
    n_cmp++; if (n_err - e0 !== 0) begin n_bad++; $display("FAIL b2b_err_cnt: got %0d want 0", n_err - e0); end
    n_cmp++; if (cap_data !== exp) begin n_bad++; $display("FAIL b2b_data: got %h want %h", cap_data, exp); end
  endtask

  task automatic test_reset_mid;
    int w0;
    logic [WDW-1:0] exp = '0;
    exp[0 +: DW] = 9'd5;
    send_str("2 2 3 ");
    n_cmp++; if (bus.o_busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_hi: got %b want 1", bus.o_busy); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_wr_data !== '0) begin n_bad++; $display("FAIL rmid_data: got %h want 0", bus.o_wr_data); end
    n_cmp++; if (bus.o_wr_row !== 3'd0 || bus.o_wr_col !== 3'd0) begin n_bad++; $display("FAIL rmid_dims: got %0d/%0d want 0/0", bus.o_wr_row, bus.o_wr_col); end
    n_cmp++; if (bus.o_err_code !== 2'd0) begin n_bad++; $display("FAIL rmid_code: got %0d want 0", bus.o_err_code); end
    @(negedge clk);
    rst_n = 1'b1;
    w0 = n_wr;
    send_str("1 1 5 ");
    idle(3);
    n_cmp++; if (n_wr - w0 !== 1 || cap_data !== exp) begin n_bad++; $display("FAIL rmid_recover: got wr=%0d data=%h want 1/%h", n_wr - w0, cap_data, exp); end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.i_enable   = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_rx_valid = 1'b0;
    test_reset();
    test_basic();
    test_separators();
    test_bad_dim();
    test_elem_ovf();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
